game_timer: RTL and testbench
=============================

# game_timer

Sink for the scoreboard clock divider's `frequencias` bus: turns the divider's 1 s square wave into one-cycle tick enables and runs the basketball game clock and shot clock. It tracks quarter time (min:s), the shot clock, the quarter number, the buzzer and game-over. Everything runs in the single 50 MHz `clock_in` domain. The display/7-segment driver consumes its outputs.

## Interface
Parameters:
- `QUARTER_MIN`, default 10: quarter length in minutes (1–15).
- `SHOT_SEC`, default 24: shot-clock reload value in seconds (1–31).
- `BUZZ_TICKS`, default 2: buzzer duration in 1 s ticks (1–7).

Ports:
- `clock_in` in 1: 50 MHz system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frequencias` in 5: divider outputs. Only bit 2 (1 s square wave) is used; the other bits are ignored.
- `start_stop` in 1: one-cycle pulse, already debounced. Toggles run/pause.
- `shot_reset` in 1: one-cycle pulse. Reloads the shot clock.
- `next_quarter` in 1: one-cycle pulse. Advances from quarter end.
- `min_out` out 4: minutes remaining.
- `sec_out` out 6: seconds remaining, 0–59.
- `shot_out` out 5: shot clock seconds.
- `quarter` out 3: current quarter, 1–4.
- `running` out 1: high only in RUN.
- `buzzer` out 1: buzzer enable.
- `game_over` out 1: high in GAME_OVER.

## Operation
- **Tick:** `frequencias[2]` passes through a 2-flop synchronizer and a delay flop. `tick` = sync2 & ~sync3, a single-cycle pulse per rising edge.
- **States:**
  - IDLE: stopped, freshly loaded.
  - RUN
  - PAUSE
  - QEND: quarter expired.
  - GAME_OVER
- **Transitions:**
  - `start_stop`: IDLE→RUN and RUN→PAUSE. PAUSE→RUN only if shot_out≠0; otherwise ignored.
  - tick in RUN: decrement the game time and the shot clock.
    - Game time: sec==0 → sec=59, min−1.
  - Game time reaches 0:0 on a tick: quarter<4 → QEND, quarter==4 → GAME_OVER. The buzzer starts in both cases.
  - shot_out reaches 0 on a tick, game time still nonzero: RUN→PAUSE and the buzzer starts.
  - Both reach 0 on the same tick: the game-time rule wins (QEND/GAME_OVER). shot_out stays 0.
  - `next_quarter` in QEND: quarter+1, min=QUARTER_MIN, sec=0, shot=SHOT_SEC, →IDLE. Ignored in every other state.
  - GAME_OVER is left only by reset. All pulse inputs are ignored there.
- **shot_reset:** loads SHOT_SEC in IDLE, RUN, PAUSE and QEND. No state change.
  - Coinciding with a RUN tick: the load wins, so shot_out=SHOT_SEC, not SHOT_SEC−1.
- **Simultaneous pulses:** `start_stop` with a tick in RUN → the decrement happens and the state becomes PAUSE in the same cycle.
- **Counters:** never wrap below 0. Zero is saturating and triggers the transitions above.
- **Buzzer:** a counter loads BUZZ_TICKS on each buzzer event. `buzzer` is high while the counter ≠0, and the counter decrements on every tick regardless of state. A new event reloads it.

## Timing
- **Reset values:**
  - min_out=QUARTER_MIN, sec_out=0, shot_out=SHOT_SEC, quarter=1
  - running=0, buzzer=0, game_over=0
  - state IDLE, synchronizer and buzzer counters 0
- **Reset mid-operation:** asynchronous; all of the above take effect immediately, with no partial update.
- **Tick latency:** `frequencias[2]` high at edge k → tick high between edges k+1 and k+2 → counters and state update at edge k+2.
- **Input pulses:** act at the same edge they are sampled on. All outputs are registered.
- **Falling edges** of `frequencias[2]` produce nothing. A level held high produces exactly one tick.

## Structure
- **Package `scoreboard_pkg`:**
  - state encoding (IDLE, RUN, PAUSE, QEND, GAME_OVER)
  - `SEC_PER_MIN` = 60
  - `NUM_QUARTERS` = 4
  - index constant `FREQ_1S_BIT` = 2
- **Sub-module `tick_edge_detect`:** synchronizer plus rising-edge pulse. Parameter-free, with ports `clock_in`, `reset_n`, `level_in`, `tick`. Reusable for the 2 s and 60 Hz bits.
- The top contains the FSM, the time, shot, quarter and buzzer counters, and the output registers.

## Test plan
All scenarios use QUARTER_MIN=1, SHOT_SEC=5, BUZZ_TICKS=2, with `frequencias[2]` driven as a square wave (period 20 cycles).
- Reset then one `start_stop` and 1 tick → 0:59, shot=4, running=1. The first update lands exactly 2 edges after the sampled rise.
- Run 5 ticks → shot=0, state PAUSE, buzzer high for 2 ticks then low, time 0:55. A `start_stop` is then ignored; `shot_reset` followed by `start_stop` resumes with shot=5.
- `shot_reset` on the same cycle as a RUN tick with shot=3 → shot=5, and time decrements normally.
- Preload the time to 0:01 with shot=1, then 1 tick → 0:00, shot=0, QEND (not PAUSE), buzzer on. `next_quarter` → quarter=2, 1:00, shot=5, IDLE.
- Quarter 4 expiry → game_over=1, running=0. All pulses are ignored; only `reset_n` low restores the reset values.
- Assert `reset_n` low mid-RUN between the sync and update edges → no tick is produced, and the reset values appear immediately without waiting for a clock.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard timing blocks.
// Provides the game FSM state encoding and time/quarter constants.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        QEND,
        GAME_OVER
    } state_t;

    localparam int SEC_PER_MIN  = 60;
    localparam int NUM_QUARTERS = 4;
    localparam int FREQ_1S_BIT  = 2;

endpackage

// File: rtl/tick_edge_detect.sv
// Synchronizes a slow divider level and emits a 1-cycle rising-edge tick.
// Ports: clock_in, reset_n (async low), level_in (async level), tick (pulse).
module tick_edge_detect (
    input  logic clock_in,
    input  logic reset_n,
    input  logic level_in,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= level_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

endmodule

// File: rtl/game_timer.sv
// Basketball game clock, shot clock, quarter counter and buzzer.
// Ports: clock_in, reset_n, frequencias[4:0], start_stop, shot_reset,
// next_quarter in; min_out, sec_out, shot_out, quarter, running, buzzer,
// game_over out (all registered).
module game_timer
    import scoreboard_pkg::*;
#(
    parameter int QUARTER_MIN = 10,
    parameter int SHOT_SEC    = 24,
    parameter int BUZZ_TICKS  = 2
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic [4:0] frequencias,
    input  logic       start_stop,
    input  logic       shot_reset,
    input  logic       next_quarter,
    output logic [3:0] min_out,
    output logic [5:0] sec_out,
    output logic [4:0] shot_out,
    output logic [2:0] quarter,
    output logic       running,
    output logic       buzzer,
    output logic       game_over
);

    localparam logic [3:0] MIN_LD  = 4'(QUARTER_MIN);
    localparam logic [4:0] SHOT_LD = 5'(SHOT_SEC);
    localparam logic [2:0] BUZZ_LD = 3'(BUZZ_TICKS);
    localparam logic [2:0] Q_LAST  = 3'(NUM_QUARTERS);
    localparam logic [5:0] SEC_TOP = 6'(SEC_PER_MIN - 1);

    logic       tick;
    logic       unused_freq;
    state_t     state_q, state_d;
    logic [3:0] min_d, min_dec;
    logic [5:0] sec_d, sec_dec;
    logic [4:0] shot_d, shot_dec;
    logic [2:0] qtr_d;
    logic [2:0] buzz_q, buzz_d;
    logic       buzz_evt;
    logic       time_zero;

    assign unused_freq = ^{frequencias[4:3], frequencias[1:0]};

    tick_edge_detect u_tick (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .level_in (frequencias[FREQ_1S_BIT]),
        .tick     (tick)
    );

    always_comb begin
        state_d  = state_q;
        min_d    = min_out;
        sec_d    = sec_out;
        shot_d   = shot_out;
        qtr_d    = quarter;
        buzz_evt = 1'b0;
        min_dec  = min_out;
        sec_dec  = sec_out;

        // Saturating min:sec borrow
        if (sec_out != 6'd0) begin
            sec_dec = sec_out - 6'd1;
        end else if (min_out != 4'd0) begin
            sec_dec = SEC_TOP;
            min_dec = min_out - 4'd1;
        end
        shot_dec = (shot_out != 5'd0) ? shot_out - 5'd1 : 5'd0;
        // A reload on the tick cycle beats the decrement
        if (shot_reset) shot_dec = SHOT_LD;
        time_zero = (min_dec == 4'd0) && (sec_dec == 6'd0);

        case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    min_d  = min_dec;
                    sec_d  = sec_dec;
                    shot_d = shot_dec;
                    // Game-time expiry outranks shot-clock expiry
                    if (time_zero) begin
                        state_d  = (quarter < Q_LAST) ? QEND : GAME_OVER;
                        buzz_evt = 1'b1;
                    end else if (shot_dec == 5'd0) begin
                        state_d  = PAUSE;
                        buzz_evt = 1'b1;
                    end else if (start_stop) begin
                        state_d = PAUSE;
                    end
                end else if (start_stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_stop && shot_out != 5'd0) state_d = RUN;
            end
            QEND: begin
                if (next_quarter) begin
                    qtr_d   = quarter + 3'd1;
                    min_d   = MIN_LD;
                    sec_d   = 6'd0;
                    shot_d  = SHOT_LD;
                    state_d = IDLE;
                end
            end
            GAME_OVER: ;
            default: state_d = IDLE;
        endcase

        if (shot_reset && state_q != GAME_OVER) shot_d = SHOT_LD;

        if (buzz_evt)
            buzz_d = BUZZ_LD;
        else if (tick && buzz_q != 3'd0)
            buzz_d = buzz_q - 3'd1;
        else
            buzz_d = buzz_q;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            min_out   <= MIN_LD;
            sec_out   <= 6'd0;
            shot_out  <= SHOT_LD;
            quarter   <= 3'd1;
            buzz_q    <= 3'd0;
            running   <= 1'b0;
            buzzer    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_out   <= min_d;
            sec_out   <= sec_d;
            shot_out  <= shot_d;
            quarter   <= qtr_d;
            buzz_q    <= buzz_d;
            running   <= (state_d == RUN);
            buzzer    <= (buzz_d != 3'd0);
            game_over <= (state_d == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer.
// Drives a 20-cycle 1 s square wave and checks hand-computed timer values.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] freq = 5'd0;
    logic       start_stop = 1'b0;
    logic       shot_reset = 1'b0;
    logic       next_quarter = 1'b0;
    logic [3:0] min_out;
    logic [5:0] sec_out;
    logic [4:0] shot_out;
    logic [2:0] quarter;
    logic       running;
    logic       buzzer;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    game_timer #(
        .QUARTER_MIN (1),
        .SHOT_SEC    (5),
        .BUZZ_TICKS  (2)
    ) dut (
        .clock_in     (clk),
        .reset_n      (reset_n),
        .frequencias  (freq),
        .start_stop   (start_stop),
        .shot_reset   (shot_reset),
        .next_quarter (next_quarter),
        .min_out      (min_out),
        .sec_out      (sec_out),
        .shot_out     (shot_out),
        .quarter      (quarter),
        .running      (running),
        .buzzer       (buzzer),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int m, input int s,
                              input int sh);
        check({tag, ".min"}, int'(min_out), m);
        check({tag, ".sec"}, int'(sec_out), s);
        check({tag, ".shot"}, int'(shot_out), sh);
    endtask

    task automatic check_reset_vals(input string tag);
        check_time(tag, 1, 0, 5);
        check({tag, ".qtr"}, int'(quarter), 1);
        check({tag, ".run"}, int'(running), 0);
        check({tag, ".buzz"}, int'(buzzer), 0);
        check({tag, ".go"}, int'(game_over), 0);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_sr();
        shot_reset = 1'b1;
        @(negedge clk);
        shot_reset = 1'b0;
    endtask

    task automatic pulse_nq();
        next_quarter = 1'b1;
        @(negedge clk);
        next_quarter = 1'b0;
    endtask

    // One square-wave period; optional shot_reset aligned with the tick
    task automatic wave(input bit with_sr);
        freq[2] = 1'b1;
        repeat (2) @(negedge clk);
        shot_reset = with_sr;
        @(negedge clk);
        shot_reset = 1'b0;
        repeat (7) @(negedge clk);
        freq[2] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        pulse_ss();
        check("start.run", int'(running), 1);

        // First tick latency: no change after edge k+1, update at k+2
        freq[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("lat.k1.sec", int'(sec_out), 0);
        check("lat.k1.min", int'(min_out), 1);
        @(negedge clk);
        check_time("lat.k2", 0, 59, 4);
        check("lat.k2.run", int'(running), 1);
        repeat (7) @(negedge clk);
        freq[2] = 1'b0;
        repeat (10) @(negedge clk);

        repeat (4) wave(1'b0);
        check_time("shot0", 0, 55, 0);
        check("shot0.run", int'(running), 0);
        check("shot0.buzz", int'(buzzer), 1);
        wave(1'b0);
        check("buzz1.buzz", int'(buzzer), 1);
        check_time("buzz1", 0, 55, 0);
        wave(1'b0);
        check("buzz2.buzz", int'(buzzer), 0);

        pulse_ss();
        check("ign_ss.run", int'(running), 0);
        pulse_sr();
        check("pause_sr.shot", int'(shot_out), 5);
        check("pause_sr.run", int'(running), 0);
        pulse_ss();
        check("resume.run", int'(running), 1);

        wave(1'b0);
        wave(1'b0);
        check_time("pre_sr", 0, 53, 3);
        wave(1'b1);
        check_time("sr_tick", 0, 52, 5);

        repeat (47) wave(1'b1);
        repeat (4) wave(1'b0);
        check_time("pre_end", 0, 1, 1);
        check("pre_end.run", int'(running), 1);

        wave(1'b0);
        check_time("qend", 0, 0, 0);
        check("qend.run", int'(running), 0);
        check("qend.buzz", int'(buzzer), 1);
        check("qend.go", int'(game_over), 0);
        pulse_nq();
        check("nq.qtr", int'(quarter), 2);
        check_time("nq", 1, 0, 5);
        check("nq.run", int'(running), 0);

        for (int q = 2; q <= 3; q++) begin
            pulse_ss();
            repeat (60) wave(1'b1);
            check("qx.run", int'(running), 0);
            pulse_nq();
        end
        check("q4.qtr", int'(quarter), 4);

        pulse_ss();
        repeat (59) wave(1'b1);
        wave(1'b0);
        check("go.go", int'(game_over), 1);
        check("go.run", int'(running), 0);
        check("go.buzz", int'(buzzer), 1);
        check_time("go", 0, 0, 4);

        pulse_ss();
        pulse_sr();
        pulse_nq();
        check("go_ign.go", int'(game_over), 1);
        check("go_ign.run", int'(running), 0);
        check("go_ign.qtr", int'(quarter), 4);
        check("go_ign.shot", int'(shot_out), 4);

        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset between sync edge and update edge drops the pending tick
        pulse_ss();
        freq[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.sec", int'(sec_out), 0);
        #2;
        reset_n = 1'b0;
        freq[2] = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_ss();
        repeat (5) @(negedge clk);
        check("post.run", int'(running), 1);
        check_time("post", 1, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
